gmii_tx_ifg_buf: RTL and testbench
==================================

// Module: gmii_tx_ifg_buf
// PURPOSE
//  Store-and-forward GMII TX buffer between the ARP/ICMP TX mux and the GMII/RGMII output stage.
//  - Accepts whole frames, each a contiguous burst of in_en high.
//  - Replays each frame with no underrun.
//  - Enforces a minimum inter-frame gap (IFG) on the output.
//  - Drops any frame that does not fit in the buffer.
// PARAMETERS
//  DEPTH      2048  buffer depth in bytes; power of 2, >= 64
//  AW         11    log2(DEPTH)
//  IFG        12    minimum idle cycles (out_en=0) between output frames; range 1..255
// PORTS
//  clk            in   1   GMII TX clock (125 MHz)
//  rst_n          in   1   asynchronous reset, active-low
//  in_en          in   1   input byte valid; one frame = one contiguous high burst
//  in_data        in   8   input byte
//  out_en         out  1   output byte valid (registered)
//  out_data       out  8   output byte (registered)
//  busy           out  1   high while FSM is not IDLE or any committed frame is pending
//  frame_drop     out  1   1-cycle pulse when an overflowing frame is discarded
//  frames_sent    out  16  count of fully transmitted frames; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, also mid-frame)
//  - Outputs: out_en=0, out_data=0, busy=0, frame_drop=0, frames_sent=0.
//  - Internal: pointers, frame count and FSM cleared; partially sent or stored frames are lost.
//  Write side
//  - Stage reg s_vld/s_data samples in_en/in_data every cycle.
//  - While s_vld=1, store word {eof, s_data}, where eof = ~in_en in that cycle.
//  - Commit: the eof write is the frame's last byte; frame_cnt increments in that cycle.
//  - Pointers are AW+1 bits. full = (wr_ptr - rd_ptr == DEPTH).
//  - start_ptr holds wr_ptr at the first byte of each frame.
//  Overflow
//  - Condition: a write is due while full.
//  - Action: wr_ptr reverts to start_ptr; further bytes of that frame are ignored until in_en falls.
//  - frame_drop pulses once in the cycle the discard ends.
//  - Committed frames are never affected.
//  - A frame longer than DEPTH is always dropped.
//  Read FSM
//  - IDLE:
//    - if frame_cnt>0 (and no gap pending), issue a read and go to SEND;
//    - if commit and read-start occur in the same cycle, the new frame is eligible the next cycle.
//  - SEND:
//    - read one word per cycle; out_en=1 for each byte in the cycle after RAM data is valid;
//    - on reading the eof word, decrement frame_cnt, go to GAP and increment frames_sent;
//    - a simultaneous commit (+1) and eof read (-1) leave frame_cnt unchanged.
//  - GAP:
//    - count out_en=0 cycles, starting at the first low cycle after the last byte;
//    - after IFG such cycles, go to IDLE.
//  - No byte gaps are inserted within a frame; out_en stays contiguous for the whole frame.
//  Latency
//  - Let F be the first cycle with in_en=0 after a frame, with the buffer idle and the gap expired.
//  - out_en first rises in cycle F+3.
//  - Frame length and order are preserved; data is bit-exact.
//  Boundaries
//  - A 1-byte frame (in_en high 1 cycle) is valid and forwarded.
//  - Input frames separated by 1 idle cycle are still output with an IFG-cycle gap.
//  - Input may stream at full rate while output is in SEND or GAP.
//  - Pointer wrap-around is transparent.
// TESTING
//  1 Single frame: 64 bytes 0x00..0x3F, buffer idle -> out_en rises at F+3; 64 identical bytes contiguous; frames_sent=1.
//  2 Back-to-back: three 60-byte frames with 1 idle cycle between inputs -> outputs separated by exactly 12 low cycles; data in order; frames_sent=3.
//  3 Overflow (DEPTH=256): 300-byte frame then a 64-byte frame
//    -> frame_drop pulses once when in_en falls after byte 300; only the 64-byte frame is output; frames_sent=1.
//  4 Full buffer (DEPTH=256): 200-byte frame committed while output is blocked in GAP, then a 100-byte frame
//    -> second frame dropped; first frame intact.
//  5 Reset mid-output: assert rst_n=0 during byte 20 of a 64-byte frame
//    -> out_en=0 immediately; after release, next 64-byte frame outputs cleanly; frames_sent counts from 0.
//  6 Edge cases: 1-byte frame 0xA5 -> one out_en cycle with 0xA5; commit coincident with eof read -> frame_cnt stays correct; next frame still sent.

Source files
------------

// File: rtl/gmii_tx_ifg_buf.sv
// Store-and-forward GMII TX buffer. Frames are replayed whole, with a minimum inter-frame gap.
// Frames that do not fit in the buffer are discarded without touching committed frames.
module gmii_tx_ifg_buf #(
   parameter int DEPTH = 2048,
   parameter int AW    = 11,
   parameter int IFG   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_en,
   input  logic [7:0]  in_data,
   output logic        out_en,
   output logic [7:0]  out_data,
   output logic        busy,
   output logic        frame_drop,
   output logic [15:0] frames_sent
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
   localparam logic [7:0]  GAP_LOAD = 8'(IFG - 1);

   state_t      state, state_next;
   logic [8:0]  mem [DEPTH];
   logic        s_vld;
   logic [7:0]  s_data;
   logic [AW:0] wr_ptr, rd_ptr, start_ptr, frame_base;
   logic [AW:0] frame_cnt;
   logic        in_frame, dropping;
   logic        eof, full, wr_due, overflow, do_write, commit;
   logic        rd_issue, ram_vld, eof_read;
   logic [8:0]  ram_q;
   logic [7:0]  gap_cnt, gap_cnt_next;

   // The byte held in the stage register is the last one of its frame when in_en has already fallen.
   always_comb begin
      eof        = ~in_en;
      full       = (wr_ptr - rd_ptr) == DEPTH_P;
      wr_due     = s_vld && !dropping;
      overflow   = wr_due && full;
      do_write   = wr_due && !full;
      commit     = do_write && eof;
      frame_base = in_frame ? start_ptr : wr_ptr;
      frame_drop = s_vld && eof && (dropping || overflow);
      busy       = (state != IDLE) || (frame_cnt != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_vld     <= 1'b0;
         s_data    <= 8'h00;
         wr_ptr    <= '0;
         start_ptr <= '0;
         in_frame  <= 1'b0;
         dropping  <= 1'b0;
      end else begin
         s_vld  <= in_en;
         s_data <= in_data;
         if (overflow) begin
            wr_ptr   <= frame_base;
            in_frame <= 1'b0;
            dropping <= !eof;
         end else if (dropping && s_vld && eof) begin
            dropping <= 1'b0;
         end else if (do_write) begin
            wr_ptr   <= wr_ptr + 1'b1;
            in_frame <= !eof;
            if (!in_frame)
               start_ptr <= wr_ptr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr[AW-1:0]] <= {eof, s_data};
      if (rd_issue)
         ram_q <= mem[rd_ptr[AW-1:0]];
   end

   // Reads stop as soon as the eof word appears, so the pointer never runs past a frame.
   // GAP runs two cycles ahead of out_en (read pipeline), hence it lasts IFG-1 cycles.
   always_comb begin
      state_next   = state;
      rd_issue     = 1'b0;
      eof_read     = 1'b0;
      gap_cnt_next = gap_cnt;
      case (state)
         IDLE: begin
            if (frame_cnt != '0) begin
               rd_issue   = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            eof_read = ram_vld && ram_q[8];
            rd_issue = !eof_read;
            if (eof_read) begin
               gap_cnt_next = GAP_LOAD;
               state_next   = (IFG == 1) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt <= 8'd1)
               state_next = IDLE;
            else
               gap_cnt_next = gap_cnt - 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gap_cnt     <= 8'h00;
         rd_ptr      <= '0;
         frame_cnt   <= '0;
         ram_vld     <= 1'b0;
         out_en      <= 1'b0;
         out_data    <= 8'h00;
         frames_sent <= 16'h0000;
      end else begin
         state    <= state_next;
         gap_cnt  <= gap_cnt_next;
         ram_vld  <= rd_issue;
         out_en   <= ram_vld;
         out_data <= ram_vld ? ram_q[7:0] : 8'h00;
         if (rd_issue)
            rd_ptr <= rd_ptr + 1'b1;
         if (eof_read)
            frames_sent <= frames_sent + 16'd1;
         case ({commit, eof_read})
            2'b10:   frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_ifg_buf.sv
// Bench for gmii_tx_ifg_buf: dut_a uses default sizing, dut_b a 256-byte buffer with a long gap
// so overflow and full-buffer cases are reachable.
module tb_gmii_tx_ifg_buf;

   localparam int HALF = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      int         len;
      logic [7:0] base;
      bit         wait_done;
      int         exp_sent;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n_v       [2];
   logic        in_en_v       [2];
   logic [7:0]  in_data_v     [2];
   logic        out_en_v      [2];
   logic [7:0]  out_data_v    [2];
   logic        busy_v        [2];
   logic        frame_drop_v  [2];
   logic [15:0] frames_sent_v [2];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   int   gaps0[$];
   int   expect_state [2];
   int   low_run      [2];
   bit   seen_frame   [2];
   int   drop_cnt     [2];
   int   drop_cyc     [2];
   int   f_cyc        [2];
   vec_t vecs         [9];

   always #HALF clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gmii_tx_ifg_buf #(.DEPTH(2048), .AW(11), .IFG(12)) dut_a (
      .clk(clk), .rst_n(rst_n_v[0]), .in_en(in_en_v[0]), .in_data(in_data_v[0]),
      .out_en(out_en_v[0]), .out_data(out_data_v[0]), .busy(busy_v[0]),
      .frame_drop(frame_drop_v[0]), .frames_sent(frames_sent_v[0])
   );

   gmii_tx_ifg_buf #(.DEPTH(256), .AW(8), .IFG(255)) dut_b (
      .clk(clk), .rst_n(rst_n_v[1]), .in_en(in_en_v[1]), .in_data(in_data_v[1]),
      .out_en(out_en_v[1]), .out_data(out_data_v[1]), .busy(busy_v[1]),
      .frame_drop(frame_drop_v[1]), .frames_sent(frames_sent_v[1])
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int sbSize(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic sbPush(input int d, input exp_t e);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic sbPop(input int d, output exp_t e);
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
   endtask

   task automatic sbClear(input int d);
      if (d == 0) sb0.delete();
      else        sb1.delete();
   endtask

   // Pops one expected byte per out_en cycle and enforces contiguous frames of the right length.
   task automatic monitorDut(input int d);
      exp_t e;
      if (!rst_n_v[d]) begin
         sbClear(d);
         expect_state[d] = 0;
         low_run[d]      = 0;
         seen_frame[d]   = 1'b0;
      end else begin
         if (frame_drop_v[d]) begin
            drop_cnt[d]++;
            drop_cyc[d] = cyc;
         end
         if (expect_state[d] == 1)
            checkOutput($sformatf("dut%0d_contiguous", d), 32'(out_en_v[d]), 32'd1);
         else if (expect_state[d] == 2)
            checkOutput($sformatf("dut%0d_frame_end", d), 32'(out_en_v[d]), 32'd0);
         if (out_en_v[d]) begin
            if (d == 0 && seen_frame[d] && low_run[d] > 0)
               gaps0.push_back(low_run[d]);
            if (sbSize(d) == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL dut%0d_unexpected_byte: got 0x%02h, expected no output", d, out_data_v[d]);
               expect_state[d] = 0;
            end else begin
               sbPop(d, e);
               checkOutput($sformatf("dut%0d_data", d), 32'(out_data_v[d]), 32'(e.data));
               expect_state[d] = e.last ? 2 : 1;
            end
            low_run[d]    = 0;
            seen_frame[d] = 1'b1;
         end else begin
            expect_state[d] = 0;
            low_run[d]++;
         end
      end
   endtask

   // Drives one frame of bytes base, base+1, ... and leaves in_en low in cycle F.
   task automatic applyStimulus(input int d, input int len, input logic [7:0] base, input bit forwarded);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         in_en_v[d]   = 1'b1;
         in_data_v[d] = base + 8'(i);
         if (forwarded) begin
            e.data = base + 8'(i);
            e.last = (i == len - 1);
            sbPush(d, e);
         end
      end
      @(posedge clk); #1;
      in_en_v[d]   = 1'b0;
      in_data_v[d] = 8'h00;
      f_cyc[d]     = cyc;
   endtask

   task automatic waitRise(input int d, input int budget);
      int n = 0;
      @(negedge clk);
      while (!out_en_v[d] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!out_en_v[d]) begin
         checks++;
         errors++;
         $display("[TB] FAIL dut%0d_rise_timeout: out_en still 0 after %0d cycles, expected 1", d, budget);
      end
   endtask

   task automatic waitIdle(input int d, input int budget);
      int n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      while (busy_v[d] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy_v[d]) begin
         checks++;
         errors++;
         $display("[TB] FAIL dut%0d_idle_timeout: busy still 1 after %0d cycles, expected 0", d, budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g0;
      int d0;

      vecs[0] = '{len: 1,   base: 8'hA5, wait_done: 1'b1, exp_sent: 5};
      vecs[1] = '{len: 10,  base: 8'h10, wait_done: 1'b0, exp_sent: 0};
      vecs[2] = '{len: 10,  base: 8'h80, wait_done: 1'b1, exp_sent: 7};
      vecs[3] = '{len: 17,  base: 8'hF0, wait_done: 1'b1, exp_sent: 8};
      vecs[4] = '{len: 500, base: 8'h33, wait_done: 1'b0, exp_sent: 0};
      vecs[5] = '{len: 500, base: 8'h77, wait_done: 1'b0, exp_sent: 0};
      vecs[6] = '{len: 600, base: 8'h11, wait_done: 1'b0, exp_sent: 0};
      vecs[7] = '{len: 300, base: 8'h99, wait_done: 1'b0, exp_sent: 0};
      vecs[8] = '{len: 200, base: 8'h5A, wait_done: 1'b1, exp_sent: 13};

      for (int d = 0; d < 2; d++) begin
         rst_n_v[d]      = 1'b0;
         in_en_v[d]      = 1'b0;
         in_data_v[d]    = 8'h00;
         expect_state[d] = 0;
         low_run[d]      = 0;
         seen_frame[d]   = 1'b0;
         drop_cnt[d]     = 0;
         drop_cyc[d]     = 0;
         f_cyc[d]        = 0;
      end

      fork
         forever begin
            @(negedge clk);
            monitorDut(0);
            monitorDut(1);
         end
      join_none

      repeat (3) @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("dut%0d_rst_out_en", d),      32'(out_en_v[d]),      32'd0);
         checkOutput($sformatf("dut%0d_rst_out_data", d),    32'(out_data_v[d]),    32'd0);
         checkOutput($sformatf("dut%0d_rst_busy", d),        32'(busy_v[d]),        32'd0);
         checkOutput($sformatf("dut%0d_rst_frame_drop", d),  32'(frame_drop_v[d]),  32'd0);
         checkOutput($sformatf("dut%0d_rst_frames_sent", d), 32'(frames_sent_v[d]), 32'd0);
      end
      rst_n_v[0] = 1'b1;
      rst_n_v[1] = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] single frame latency");
      applyStimulus(0, 64, 8'h00, 1'b1);
      waitRise(0, 20);
      checkOutput("t1_latency", 32'(cyc - f_cyc[0]), 32'd3);
      waitIdle(0, 500);
      checkOutput("t1_frames_sent", 32'(frames_sent_v[0]), 32'd1);
      checkOutput("t1_sb_empty", 32'(sbSize(0)), 32'd0);

      $display("[TB] back-to-back frames");
      g0 = gaps0.size();
      applyStimulus(0, 60, 8'h40, 1'b1);
      applyStimulus(0, 60, 8'h80, 1'b1);
      applyStimulus(0, 60, 8'hC0, 1'b1);
      waitIdle(0, 1000);
      checkOutput("t2_gap_count", 32'(gaps0.size() - g0), 32'd3);
      if (gaps0.size() >= g0 + 3) begin
         checkOutput("t2_ifg_1", 32'(gaps0[g0+1]), 32'd12);
         checkOutput("t2_ifg_2", 32'(gaps0[g0+2]), 32'd12);
      end
      checkOutput("t2_frames_sent", 32'(frames_sent_v[0]), 32'd4);
      checkOutput("t2_sb_empty", 32'(sbSize(0)), 32'd0);

      $display("[TB] table vectors");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, vecs[i].len, vecs[i].base, 1'b1);
         if (vecs[i].wait_done) begin
            waitIdle(0, 3000);
            checkOutput($sformatf("vec%0d_frames_sent", i), 32'(frames_sent_v[0]), 32'(vecs[i].exp_sent));
            checkOutput($sformatf("vec%0d_sb_empty", i), 32'(sbSize(0)), 32'd0);
         end
      end

      $display("[TB] reset during output");
      applyStimulus(0, 64, 8'h20, 1'b1);
      waitRise(0, 20);
      repeat (19) @(posedge clk);
      #2;
      rst_n_v[0] = 1'b0;
      #1;
      checkOutput("t5_out_en_async", 32'(out_en_v[0]), 32'd0);
      checkOutput("t5_out_data_async", 32'(out_data_v[0]), 32'd0);
      checkOutput("t5_frames_sent_rst", 32'(frames_sent_v[0]), 32'd0);
      checkOutput("t5_busy_rst", 32'(busy_v[0]), 32'd0);
      repeat (3) @(posedge clk); #1;
      rst_n_v[0] = 1'b1;
      repeat (2) @(posedge clk);
      applyStimulus(0, 64, 8'h61, 1'b1);
      waitIdle(0, 500);
      checkOutput("t5_frames_sent", 32'(frames_sent_v[0]), 32'd1);
      checkOutput("t5_sb_empty", 32'(sbSize(0)), 32'd0);

      $display("[TB] oversize frame drop");
      d0 = drop_cnt[1];
      applyStimulus(1, 300, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      checkOutput("t3_drop_pulses", 32'(drop_cnt[1] - d0), 32'd1);
      checkOutput("t3_drop_cycle", 32'(drop_cyc[1] - f_cyc[1]), 32'd0);
      applyStimulus(1, 64, 8'h40, 1'b1);
      waitIdle(1, 2000);
      checkOutput("t3_frames_sent", 32'(frames_sent_v[1]), 32'd1);
      checkOutput("t3_sb_empty", 32'(sbSize(1)), 32'd0);

      $display("[TB] full buffer while in gap");
      d0 = drop_cnt[1];
      applyStimulus(1, 40, 8'h80, 1'b1);
      applyStimulus(1, 200, 8'h10, 1'b1);
      applyStimulus(1, 100, 8'hC0, 1'b0);
      repeat (3) @(posedge clk);
      checkOutput("t4_drop_pulses", 32'(drop_cnt[1] - d0), 32'd1);
      checkOutput("t4_drop_cycle", 32'(drop_cyc[1] - f_cyc[1]), 32'd0);
      waitIdle(1, 2000);
      checkOutput("t4_frames_sent", 32'(frames_sent_v[1]), 32'd3);
      checkOutput("t4_sb_empty", 32'(sbSize(1)), 32'd0);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
